// File: rtl/exe_mdu.sv
// Execute stage: operand muxing, ALU, branch resolution and an iterative RV32M unit
// behind valid/ready handshakes. Define EXE_FAST_MUL_EN for single-cycle multiplies.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_cntr,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ov,
    output logic             o_z
);
    localparam int SW = $clog2(WIDTH);
    logic [SW-1:0] w_sh;
    assign w_sh = i_b[SW-1:0];

    // For subtracts, ov reports a < b so branches can resolve from {ov,z}
    always_comb begin
        o_result = '0;
        o_ov     = 1'b0;
        case (i_cntr)
            4'b0000: begin
                o_result = i_a + i_b;
                o_ov     = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            4'b1000: begin
                o_result = i_a - i_b;
                o_ov     = $signed(i_a) < $signed(i_b);
            end
            4'b1001: begin
                o_result = i_a - i_b;
                o_ov     = i_a < i_b;
            end
            4'b0001: o_result = i_a << w_sh;
            4'b0010: o_result = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            4'b0011: o_result = {{(WIDTH-1){1'b0}}, i_a < i_b};
            4'b0100: o_result = i_a ^ i_b;
            4'b0101: o_result = i_a >> w_sh;
            4'b1101: o_result = $unsigned($signed(i_a) >>> w_sh);
            4'b0110: o_result = i_a | i_b;
            4'b0111: o_result = i_a & i_b;
            4'b1111: o_result = i_b;
            default: o_result = '0;
        endcase
    end

    assign o_z = (o_result == '0);
endmodule

module exe_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_md_en,
    input  logic [2:0]       i_md_op,
    input  logic [3:0]       i_alu_cntr,
    input  logic [1:0]       i_ALUa,
    input  logic [1:0]       i_ALUb,
    input  logic [WIDTH-1:0] i_Rd1,
    input  logic [WIDTH-1:0] i_Rd2,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [WIDTH-1:0] i_pc_in,
    input  logic [2:0]       i_branch_cntr,
    input  logic [1:0]       i_Memtoreg_in,
    input  logic [2:0]       i_Ld_cntr_in,
    input  logic [1:0]       i_St_cntr_in,
    input  logic             i_RegW_in,
    input  logic [4:0]       i_wr_addr_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_alu_result,
    output logic             o_ov_flag,
    output logic             o_z_flag,
    output logic             o_pcbranch,
    output logic [WIDTH-1:0] o_Rd2_out,
    output logic [1:0]       o_Memtoreg_out,
    output logic [2:0]       o_Ld_cntr_out,
    output logic [1:0]       o_St_cntr_out,
    output logic             o_RegW_out,
    output logic [4:0]       o_wr_addr_out,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             r_out_valid, r_ov, r_z, r_pcb, r_busy;
    logic [WIDTH-1:0] r_result, r_rd2_out;
    logic [12:0]      r_out_sb;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo, r_opnd, r_rd2, r_spec_res;
    logic             r_neg, r_special;
    logic [12:0]      r_md_sb;

    logic [WIDTH-1:0] w_a, w_b, w_alu_res;
    logic             w_alu_ov, w_alu_z, w_pcb;
    logic [12:0]      w_sb_in;
    logic             w_accept, w_slot_free, w_fast;
    logic [WIDTH-1:0] w_fast_res;

    assign w_slot_free = !r_out_valid || i_out_ready;
    assign o_in_ready  = !r_busy && w_slot_free;
    assign w_accept    = i_in_valid && o_in_ready && !i_flush;
    assign w_sb_in     = {i_Memtoreg_in, i_Ld_cntr_in, i_St_cntr_in, i_RegW_in, i_wr_addr_in};

    always_comb begin
        case (i_ALUa)
            2'b01:   w_a = '0;
            2'b10:   w_a = i_pc_in;
            default: w_a = i_Rd1;
        endcase
        case (i_ALUb)
            2'b00:   w_b = i_Rd2;
            2'b01:   w_b = {{(WIDTH-5){1'b0}}, i_Rd2[4:0]};
            2'b10:   w_b = i_imm;
            default: w_b = WIDTH'(4);
        endcase
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_a(w_a), .i_b(w_b), .i_cntr(i_alu_cntr),
        .o_result(w_alu_res), .o_ov(w_alu_ov), .o_z(w_alu_z)
    );

    always_comb begin
        case (i_branch_cntr)
            3'b001:  w_pcb = !w_alu_ov && w_alu_z;
            3'b010:  w_pcb = !w_alu_z;
            3'b011:  w_pcb = w_alu_ov && !w_alu_z;
            3'b100:  w_pcb = !w_alu_ov;
            default: w_pcb = 1'b0;
        endcase
    end

    // Operand preparation at acceptance: magnitudes, result sign, divide special cases
    logic             w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_res_neg, w_div0, w_ovf;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_spec;
    assign w_a_sgn   = (i_md_op == 3'd1) || (i_md_op == 3'd2) || (i_md_op == 3'd4) || (i_md_op == 3'd6);
    assign w_b_sgn   = (i_md_op == 3'd1) || (i_md_op == 3'd4) || (i_md_op == 3'd6);
    assign w_a_neg   = w_a_sgn && i_Rd1[WIDTH-1];
    assign w_b_neg   = w_b_sgn && i_Rd2[WIDTH-1];
    assign w_mag_a   = w_a_neg ? -i_Rd1 : i_Rd1;
    assign w_mag_b   = w_b_neg ? -i_Rd2 : i_Rd2;
    assign w_res_neg = (i_md_op[2] && i_md_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div0    = i_md_op[2] && (i_Rd2 == '0);
    assign w_ovf     = ((i_md_op == 3'd4) || (i_md_op == 3'd6)) &&
                       (i_Rd1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_Rd2 == '1);
    assign w_spec    = w_div0 ? (i_md_op[1] ? i_Rd1 : '1) : (i_md_op[1] ? '0 : i_Rd1);

`ifdef EXE_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fa, w_fb, w_fp;
    assign w_fa       = {{WIDTH{w_a_sgn && i_Rd1[WIDTH-1]}}, i_Rd1};
    assign w_fb       = {{WIDTH{w_b_sgn && i_Rd2[WIDTH-1]}}, i_Rd2};
    assign w_fp       = w_fa * w_fb;
    assign w_fast     = i_md_en && !i_md_op[2];
    assign w_fast_res = (i_md_op == 3'd0) ? w_fp[WIDTH-1:0] : w_fp[2*WIDTH-1:WIDTH];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // One iteration: shift-add multiply or restoring divide step
    logic [WIDTH:0]   w_sum, w_shr, w_trial, w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    assign w_sum   = r_lo[0] ? (r_hi + {1'b0, r_opnd}) : r_hi;
    assign w_shr   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_trial = w_shr - {1'b0, r_opnd};
    always_comb begin
        if (!r_op[2]) begin
            w_step_hi = {1'b0, w_sum[WIDTH:1]};
            w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (w_shr >= {1'b0, r_opnd}) begin
            w_step_hi = w_trial;
            w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_step_hi = w_shr;
            w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_q, w_r, w_md_res, w_fin;
    logic               w_done;
    assign w_prod   = {r_hi[WIDTH-1:0], r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_q      = r_neg ? -r_lo : r_lo;
    assign w_r      = r_neg ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
    always_comb begin
        case (r_op)
            3'd0:             w_md_res = w_prod_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: w_md_res = w_prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       w_md_res = w_q;
            default:          w_md_res = w_r;
        endcase
    end
    assign w_fin  = r_special ? r_spec_res : w_md_res;
    assign w_done = r_special || (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0; r_ov <= 1'b0; r_z <= 1'b0; r_pcb <= 1'b0;
            r_busy <= 1'b0; r_result <= '0; r_rd2_out <= '0; r_out_sb <= '0;
            r_cnt <= '0; r_op <= '0; r_hi <= '0; r_lo <= '0; r_opnd <= '0;
            r_rd2 <= '0; r_spec_res <= '0; r_neg <= 1'b0; r_special <= 1'b0;
            r_md_sb <= '0;
        end else begin
            if (r_out_valid && i_out_ready)
                r_out_valid <= 1'b0;
            if (i_flush) begin
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else if (w_accept) begin
                if (i_md_en && !w_fast) begin
                    r_busy     <= 1'b1;
                    r_cnt      <= CW'(WIDTH);
                    r_op       <= i_md_op;
                    r_hi       <= '0;
                    r_lo       <= w_mag_a;
                    r_opnd     <= w_mag_b;
                    r_neg      <= w_res_neg;
                    r_special  <= w_div0 || w_ovf;
                    r_spec_res <= w_spec;
                    r_rd2      <= i_Rd2;
                    r_md_sb    <= w_sb_in;
                end else begin
                    r_out_valid <= 1'b1;
                    r_result    <= i_md_en ? w_fast_res : w_alu_res;
                    r_ov        <= i_md_en ? 1'b0 : w_alu_ov;
                    r_z         <= i_md_en ? (w_fast_res == '0) : w_alu_z;
                    r_pcb       <= i_md_en ? 1'b0 : w_pcb;
                    r_rd2_out   <= i_Rd2;
                    r_out_sb    <= w_sb_in;
                end
            end else if (r_busy) begin
                if (w_done) begin
                    // A full, stalled slot holds the finished result back
                    if (w_slot_free) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_fin;
                        r_ov        <= 1'b0;
                        r_z         <= (w_fin == '0);
                        r_pcb       <= 1'b0;
                        r_rd2_out   <= r_rd2;
                        r_out_sb    <= r_md_sb;
                    end
                end else begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_alu_result   = r_result;
    assign o_ov_flag      = r_ov;
    assign o_z_flag       = r_z;
    assign o_pcbranch     = r_pcb;
    assign o_Rd2_out      = r_rd2_out;
    assign o_Memtoreg_out = r_out_sb[12:11];
    assign o_Ld_cntr_out  = r_out_sb[10:8];
    assign o_St_cntr_out  = r_out_sb[7:6];
    assign o_RegW_out     = r_out_sb[5];
    assign o_wr_addr_out  = r_out_sb[4:0];
    assign o_busy         = r_busy;
endmodule

// File: tb/tb_exe_mdu.sv
// Directed bench for exe_mdu: ALU ops, branches, iterative MDU, special divides,
// flush, back-pressure and reset mid-iteration.
module tb_exe_mdu;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic        md_en = 1'b0;
    logic [2:0]  md_op = '0;
    logic [3:0]  alu_cntr = '0;
    logic [1:0]  ALUa = 2'b11, ALUb = 2'b00;
    logic [31:0] Rd1 = '0, Rd2 = '0, imm = '0, pc_in = '0;
    logic [2:0]  branch_cntr = '0;
    logic [1:0]  Memtoreg_in = '0, St_cntr_in = '0;
    logic [2:0]  Ld_cntr_in = '0;
    logic        RegW_in = 1'b0;
    logic [4:0]  wr_addr_in = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] alu_result, Rd2_out;
    logic        ov_flag, z_flag, pcbranch, RegW_out, busy;
    logic [1:0]  Memtoreg_out, St_cntr_out;
    logic [2:0]  Ld_cntr_out;
    logic [4:0]  wr_addr_out;

    int errors = 0, checks = 0;
    int lat, nrdy;
    logic seen;

`ifdef EXE_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    exe_mdu #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_md_en(md_en), .i_md_op(md_op), .i_alu_cntr(alu_cntr), .i_ALUa(ALUa), .i_ALUb(ALUb),
        .i_Rd1(Rd1), .i_Rd2(Rd2), .i_imm(imm), .i_pc_in(pc_in), .i_branch_cntr(branch_cntr),
        .i_Memtoreg_in(Memtoreg_in), .i_Ld_cntr_in(Ld_cntr_in), .i_St_cntr_in(St_cntr_in),
        .i_RegW_in(RegW_in), .i_wr_addr_in(wr_addr_in), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_alu_result(alu_result), .o_ov_flag(ov_flag),
        .o_z_flag(z_flag), .o_pcbranch(pcbranch), .o_Rd2_out(Rd2_out),
        .o_Memtoreg_out(Memtoreg_out), .o_Ld_cntr_out(Ld_cntr_out), .o_St_cntr_out(St_cntr_out),
        .o_RegW_out(RegW_out), .o_wr_addr_out(wr_addr_out), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] br);
        md_en = 1'b0; ALUa = 2'b11; ALUb = 2'b00;
        alu_cntr = c; Rd1 = a; Rd2 = b; branch_cntr = br; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; branch_cntr = '0;
    endtask

    // Accept one MDU op, then count cycles until the slot fills (bounded)
    task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_en = 1'b1; md_op = op; Rd1 = a; Rd2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; md_en = 1'b0;
        lat = 0; nrdy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) nrdy++;
            tick();
            lat++;
        end
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_pcbranch", {31'd0, pcbranch}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr_out}, 32'd0);

        wr_addr_in = 5'd9; RegW_in = 1'b1;
        alu_op(4'b0000, 32'd5, 32'd7, 3'b000);
        chk("add_result", alu_result, 32'd12);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_z", {31'd0, z_flag}, 32'd0);
        chk("add_wr_addr", {27'd0, wr_addr_out}, 32'd9);
        chk("add_regw", {31'd0, RegW_out}, 32'd1);

        alu_op(4'b1000, 32'h10, 32'h10, 3'b001);
        chk("beq_pcb", {31'd0, pcbranch}, 32'd1);
        chk("beq_z", {31'd0, z_flag}, 32'd1);
        alu_op(4'b1000, 32'h10, 32'h10, 3'b010);
        chk("bne_pcb", {31'd0, pcbranch}, 32'd0);
        alu_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 3'b011);
        chk("blt_pcb", {31'd0, pcbranch}, 32'd1);
        alu_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 3'b100);
        chk("bge_pcb", {31'd0, pcbranch}, 32'd0);

        ALUa = 2'b10; ALUb = 2'b11; pc_in = 32'h1000; alu_cntr = 4'b0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pc_plus4", alu_result, 32'h1004);
        ALUa = 2'b11; ALUb = 2'b10; Rd1 = 32'd100; imm = 32'hFFFF_FFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ALUb = 2'b00;
        chk("add_imm", alu_result, 32'd99);

        wr_addr_in = 5'd3;
        md_en = 1'b1; md_op = 3'd4; Rd1 = 32'hFFFF_FFF9; Rd2 = 32'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; md_en = 1'b0; wr_addr_in = 5'd0;
        chk("div_busy", {31'd0, busy}, 32'd1);
        chk("div_in_ready", {31'd0, in_ready}, 32'd0);
        lat = 0; nrdy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) nrdy++;
            tick();
            lat++;
        end
        chk("div_latency", lat, 32'd33);
        chk("div_stall_cycles", nrdy, 32'd33);
        chk("div_result", alu_result, 32'hFFFF_FFFD);
        chk("div_wr_addr", {27'd0, wr_addr_out}, 32'd3);
        chk("div_busy_done", {31'd0, busy}, 32'd0);

        md_run(3'd6, 32'hFFFF_FFF9, 32'd2);
        chk("rem_latency", lat, 32'd33);
        chk("rem_result", alu_result, 32'hFFFF_FFFF);
        md_run(3'd5, 32'd100, 32'd7);
        chk("divu_result", alu_result, 32'd14);
        md_run(3'd7, 32'd100, 32'd7);
        chk("remu_result", alu_result, 32'd2);

        md_run(3'd4, 32'd55, 32'd0);
        chk("div0_latency", lat, 32'd1);
        chk("div0_result", alu_result, 32'hFFFF_FFFF);
        md_run(3'd7, 32'd123, 32'd0);
        chk("remu0_result", alu_result, 32'd123);
        md_run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_latency", lat, 32'd1);
        chk("divovf_result", alu_result, 32'h8000_0000);
        md_run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("removf_result", alu_result, 32'd0);
        chk("removf_z", {31'd0, z_flag}, 32'd1);

        md_run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu_latency", lat, MUL_LAT);
        chk("mulhu_result", alu_result, 32'hFFFF_FFFE);
        chk("mulhu_ov", {31'd0, ov_flag}, 32'd0);
        md_run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulh_result", alu_result, 32'd0);
        chk("mulh_z", {31'd0, z_flag}, 32'd1);
        md_run(3'd0, 32'hFFFF_FFFD, 32'd5);
        chk("mul_result", alu_result, 32'hFFFF_FFF1);
        md_run(3'd2, 32'hFFFF_FFFF, 32'd2);
        chk("mulhsu_result", alu_result, 32'hFFFF_FFFF);
        tick();

        md_en = 1'b1; md_op = 3'd5; Rd1 = 32'd100; Rd2 = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; md_en = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("flush_no_result", {31'd0, seen}, 32'd0);

        flush = 1'b1;
        alu_op(4'b0000, 32'd1, 32'd1, 3'b000);
        flush = 1'b0;
        chk("flush_blocks_accept", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        alu_op(4'b0000, 32'd1, 32'd2, 3'b000);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        Rd1 = 32'd5; Rd2 = 32'd5; in_valid = 1'b1;
        tick();
        chk("hold_result", alu_result, 32'd3);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("drain_new_result", alu_result, 32'd10);

        wr_addr_in = 5'd7;
        md_en = 1'b1; md_op = 3'd4; Rd1 = 32'hFFFF_FFF9; Rd2 = 32'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; md_en = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_result", alu_result, 32'd0);
        chk("rst_mid_regw", {31'd0, RegW_out}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_no_result", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
